// File: rtl/intc_prio_nest.sv
// Nestable priority interrupt controller: latches edge/level requests, masks them,
// presents the highest eligible source and tracks in-service handlers via ACK/EOI.
// Optional macro INTC_NEST_EN enables pre-emption by higher-priority sources.
module intc_prio_nest #(
  parameter int unsigned       N_SRC      = 8,
  parameter int unsigned       CODE_W     = 4,
  parameter logic [N_SRC-1:0]  LEVEL_MASK = '0
) (
  input  logic              in_CLK,
  input  logic              in_RST,
  input  logic [N_SRC-1:0]  in_IR,
  input  logic [N_SRC-1:0]  in_IG,
  input  logic [N_SRC-1:0]  in_INM,
  input  logic              in_IE,
  input  logic              in_ACK,
  input  logic              in_EOI,
  output logic [CODE_W-1:0] out_code,
  output logic              out_break,
  output logic [CODE_W-1:0] out_vec,
  output logic [N_SRC-1:0]  out_isr,
  output logic [N_SRC-1:0]  IR
);

  localparam logic [N_SRC-1:0] EDGE_MASK = ~LEVEL_MASK;

  logic [N_SRC-1:0]  rir_q,  rir_d;
  logic [N_SRC-1:0]  prev_q, prev_d;
  logic [N_SRC-1:0]  pend_q, pend_d;
  logic [N_SRC-1:0]  isr_q,  isr_d;
  logic [CODE_W-1:0] vec_q,  vec_d;

  logic [N_SRC-1:0]  rise_c;
  logic [N_SRC-1:0]  elig_c;
  logic [CODE_W-1:0] win_idx_c;
  logic              win_vld_c;
  logic [N_SRC-1:0]  win_oh_c;
  logic              allowed_c;
  logic              ack_fire_c;
  logic [N_SRC-1:0]  eoi_clr_c;
  logic [N_SRC-1:0]  clr_c;

  // Level sources follow the sampled line directly; edge sources use the latch.
  assign IR     = (pend_q & EDGE_MASK) | (rir_q & LEVEL_MASK);
  assign rise_c = rir_q & ~prev_q;
  assign elig_c = IR & ~in_INM;

  // Highest set index wins; ascending scan lets the last hit overwrite.
  always_comb begin
    win_idx_c = '0;
    win_vld_c = 1'b0;
    win_oh_c  = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (elig_c[i]) begin
        win_idx_c = CODE_W'(i);
        win_vld_c = 1'b1;
        win_oh_c  = '0;
        win_oh_c[i] = 1'b1;
      end
    end
  end

`ifdef INTC_NEST_EN
  // Allowed only when nothing at equal or higher priority is in service.
  always_comb begin
    allowed_c = 1'b1;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (isr_q[i] && (CODE_W'(i) >= win_idx_c)) begin
        allowed_c = 1'b0;
      end
    end
  end
`else
  assign allowed_c = (isr_q == '0);
`endif

  assign out_code   = (win_vld_c && allowed_c) ? CODE_W'(win_idx_c + CODE_W'(1)) : '0;
  assign out_break  = win_vld_c & allowed_c & in_IE;
  assign ack_fire_c = in_ACK & out_break;
  assign out_isr    = isr_q;
  assign out_vec    = vec_q;

  // EOI retires the highest in-service bit of the pre-ACK register.
  always_comb begin
    eoi_clr_c = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (isr_q[i]) begin
        eoi_clr_c    = '0;
        eoi_clr_c[i] = 1'b1;
      end
    end
  end

  // Next-state for sampling, pending latch, in-service and vector registers.
  always_comb begin
    rir_d  = in_IR;
    prev_d = rir_q;
    clr_c  = in_IG | (ack_fire_c ? win_oh_c : '0);
    pend_d = ((pend_q & ~clr_c) | rise_c) & EDGE_MASK;
    isr_d  = isr_q;
    if (in_EOI) begin
      isr_d = isr_d & ~eoi_clr_c;
    end
    if (ack_fire_c) begin
      isr_d = isr_d | win_oh_c;
    end
    vec_d = ack_fire_c ? out_code : vec_q;
  end

  always_ff @(posedge in_CLK or negedge in_RST) begin
    if (!in_RST) begin
      rir_q  <= '0;
      prev_q <= '0;
      pend_q <= '0;
      isr_q  <= '0;
      vec_q  <= '0;
    end else begin
      rir_q  <= rir_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
      isr_q  <= isr_d;
      vec_q  <= vec_d;
    end
  end

endmodule

// File: doc/intc_prio_nest.md
# intc_prio_nest

Parametrised, nestable priority interrupt controller placed between the peripheral interrupt lines and the CPU control unit. It latches up to `N_SRC` requests, applies per-source masking and a global enable, and presents the highest-priority eligible request as an encoded code plus a break request. A CPU acknowledge/end-of-interrupt handshake tracks which sources are in service, so higher-priority requests can pre-empt a running handler.

## Interface
- `N_SRC`, 8: number of interrupt sources; legal range 1..15.
- `CODE_W`, 4: width of `out_code`; must satisfy 2^`CODE_W` > `N_SRC`.
- `LEVEL_MASK`, all zeros: `N_SRC`-bit mask.
  - Bit i = 1: source i is level-sensitive.
  - Bit i = 0: source i is rising-edge-latched.

Ports:
- `in_CLK`  in  1  single clock; all state updates on its rising edge.
- `in_RST`  in  1  asynchronous, active-low reset.
- `in_IR`  in  `N_SRC`  raw request lines; bit i is source i. Higher index means higher priority.
- `in_IG`  in  `N_SRC`  per-source pending clear, sampled each clock.
- `in_INM`  in  `N_SRC`  per-source mask; 1 = masked.
- `in_IE`  in  1  global interrupt enable.
- `in_ACK`  in  1  one-cycle pulse: CPU accepts the currently presented request.
- `in_EOI`  in  1  one-cycle pulse: CPU finished the highest in-service handler.
- `out_code`  out  `CODE_W`  0 = no request; otherwise source index + 1.
- `out_break`  out  1  interrupt request to the CPU.
- `out_vec`  out  `CODE_W`  code captured at the last accepted `in_ACK`.
- `out_isr`  out  `N_SRC`  in-service register.
- `IR`  out  `N_SRC`  pending register.

## Operation
- Sampling: `rIR` registers `in_IR` every clock.
- Edge source (`LEVEL_MASK`[i]=0):
  - `IR`[i] sets when `rIR`[i] rises: registered `rIR` is 1 and the previous sample was 0.
  - Stays set until cleared.
- Level source (`LEVEL_MASK`[i]=1): `IR`[i] equals `rIR`[i]; `in_IG` and `in_ACK` do not clear it.
- Clearing an edge source's pending bit: by `in_IG`[i], or by `in_ACK` when i is the presented source.
  - A new edge in the same cycle as a clear wins: the bit stays 1.
- Eligibility:
  - Eligible set E = `IR` & ~`in_INM`.
  - Winner = highest set index of E.
  - Winner is "allowed" per the nesting rule in Configuration.
- Outputs (combinational from registers):
  - Winner exists and is allowed: `out_code` = winner+1, `out_break` = `in_IE`.
  - Otherwise: `out_code` = 0, `out_break` = 0.
- `in_ACK` with `out_break`=1:
  - Set `out_isr`[winner].
  - Clear `IR`[winner] (edge sources only).
  - Set `out_vec` = `out_code`.
- `in_ACK` with `out_break`=0: ignored, no state change.
- `in_EOI`:
  - Clears the highest set bit of `out_isr`.
  - With `out_isr`=0 it is a no-op.
- `in_EOI` and `in_ACK` in the same cycle: the EOI clear is computed on the pre-ACK `out_isr`, then the ACK bit is set. Both take effect at one edge.

## Timing
- Reset (`in_RST`=0, asynchronous): `rIR`, previous sample, `IR`, `out_isr` and `out_vec` all go to 0. Consequently `out_code`=0 and `out_break`=0.
- Reset asserted mid-handler drops all pending and in-service state.
- Request latency:
  - `in_IR` rising before edge t is captured in `rIR` at edge t.
  - `IR` sets at edge t+1.
  - `out_break` is valid after edge t+1 (2 clocks).
- Level-source latency: 1 clock for both assertion and deassertion.
- Mask and enable: `in_INM` and `in_IE` changes affect `out_code`/`out_break` in the same cycle (combinational).
- ACK latency: `out_isr` and `out_vec` update at the edge sampling `in_ACK`. The next winner is presented the following cycle.
- Back-to-back ACKs on consecutive cycles are legal; each sees the state left by the previous one.

## Configuration
- Macro `INTC_NEST_EN`.
- Defined:
  - Winner w is allowed if `out_isr` has no set bit at index ≥ w.
  - A higher-priority request pre-empts a lower in-service handler; an equal or lower one waits.
  - Up to `N_SRC` nesting levels.
- Undefined:
  - Winner is allowed only when `out_isr`=0: single-level, with no pre-emption.
  - `out_isr` never has more than one bit set.

## Test plan
- Reset, then pulse `in_IR`[2]=1 for 1 clock (edge source) -> `IR`[2]=1 two edges later, `out_code`=3, `out_break`=1 with `in_IE`=1. With `in_IE`=0: `out_code`=3, `out_break`=0.
- Pending `IR`=8'b0000_0101, `in_INM`=8'b0000_0100 -> `out_code`=1. Clear the mask -> `out_code`=3 in the same cycle.
- ACK source 1, then raise source 5:
  - Nesting defined: `out_code`=6, `out_break`=1.
  - Nesting undefined: `out_break`=0 until `in_EOI`.
  - After `in_EOI` (`INTC_NEST_EN` defined): `out_isr` clears bit 5 first, then bit 1.
- `in_IG`[3]=1 in the same cycle as a new rising edge on source 3 -> `IR`[3] remains 1.
- Level source 4 (`LEVEL_MASK`=8'h10):
  - Hold `in_IR`[4]=1 -> `IR`[4]=1 despite `in_IG`[4]=1.
  - Drop `in_IR`[4] -> `IR`[4]=0 one edge later.
- Assert `in_RST`=0 asynchronously mid-handler (`out_isr`=8'h22) -> `out_isr`, `IR`, `out_vec`, `out_code` and `out_break` are 0 immediately, before the next clock.
